// File: rtl/cache_mem_responder_pkg.sv
// rtl/cache_mem_responder_pkg.sv - shared RAM-state and arbiter-state types
// for the cache memory responder.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package dp_types_pkg;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} memctl_state_t;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/cache_mem_responder_stats.sv
// rtl/cache_mem_responder_stats.sv - saturating event counters for the
// cache memory responder.
module memctl_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_read,
  input  logic        d_write,
  input  logic        i_read,
  input  logic        ram_err,
  input  logic        starve_force,
  output logic [31:0] stat_dr,
  output logic [31:0] stat_dw,
  output logic [31:0] stat_ir,
  output logic [31:0] stat_err,
  output logic [31:0] stat_starve
);
  logic [31:0] cnt [5];
  logic [4:0]  inc;

  assign inc = {starve_force, ram_err, i_read, d_write, d_read};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++)
        if (inc[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 32'd1;
    end
  end

  assign stat_dr     = cnt[0];
  assign stat_dw     = cnt[1];
  assign stat_ir     = cnt[2];
  assign stat_err    = cnt[3];
  assign stat_starve = cnt[4];
endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - icache/dcache arbiter onto a single-ported RAM;
// optional counter bank enabled by MEMCTL_STATS_EN.
module cache_mem_responder
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
`ifdef MEMCTL_STATS_EN
  ,
  output logic [31:0] stat_dr,
  output logic [31:0] stat_dw,
  output logic [31:0] stat_ir,
  output logic [31:0] stat_err,
  output logic [31:0] stat_starve
`endif
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  memctl_state_t       state, next_state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W:0]   cnt_inc;
  logic                d_req, d_done, i_done, starved, d_lock;

  assign d_req   = dREN | dWEN;
  assign d_done  = (state == DGRANT) && d_req && (ramstate == ACCESS);
  assign i_done  = (state == IGRANT) && iREN && (ramstate == ACCESS);
  assign starved = iREN && (starve_cnt >= LIMIT);
  assign cnt_inc = {1'b0, starve_cnt} + (STARVE_W + 1)'(1);
  // Keep a block's two words together unless this completion hits the starve limit.
  assign d_lock  = !daddr[2] && !(iREN && (cnt_inc >= {1'b0, LIMIT}));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (d_req && !starved) next_state = DGRANT;
        else if (iREN)         next_state = IGRANT;
      end
      DGRANT: begin
        if (!d_req)      next_state = IDLE;
        else if (d_done) next_state = d_lock ? DGRANT : IDLE;
      end
      IGRANT: begin
        if (!iREN || i_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
    dwait = ~d_done;
    iwait = ~i_done;
    dload = d_done ? ramload : '0;
    iload = i_done ? ramload : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                  starve_cnt <= '0;
    else if (!iREN || i_done)   starve_cnt <= '0;
    else if (d_done && starve_cnt != '1)
      starve_cnt <= starve_cnt + STARVE_W'(1);
  end

`ifdef MEMCTL_STATS_EN
  logic ram_err;
  assign ram_err = ((state == DGRANT && d_req) || (state == IGRANT && iREN)) &&
                   (ramstate == ERROR);

  memctl_stats u_stats (
    .clk          (CLK),
    .rst_n        (nRST),
    .d_read       (d_done && !dWEN),
    .d_write      (d_done && dWEN),
    .i_read       (i_done),
    .ram_err      (ram_err),
    .starve_force (state == IDLE && d_req && starved),
    .stat_dr      (stat_dr),
    .stat_dw      (stat_dw),
    .stat_ir      (stat_ir),
    .stat_err     (stat_err),
    .stat_starve  (stat_starve)
  );
`endif
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder
// with a latency-programmable RAM model.
module tb_cache_mem_responder;
  import cpu_types_pkg::*;
  import dp_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMCTL_STATS_EN
  logic [31:0] stat_dr, stat_dw, stat_ir, stat_err, stat_starve;
`endif

  cache_mem_responder #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMCTL_STATS_EN
    , .stat_dr(stat_dr), .stat_dw(stat_dw), .stat_ir(stat_ir),
    .stat_err(stat_err), .stat_starve(stat_starve)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, fails = 0, cyc = 0;
  int   lat = 0, use_err = 0, wait_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RAM model: read data is address ^ 0xA5A50000, answered after lat stall cycles.
  always @(posedge CLK) begin
    #2;
    if (ramstate == ACCESS) wait_cnt = lat;
    if (ramREN || ramWEN) begin
      if (wait_cnt == 0) begin
        ramstate = ACCESS;
        ramload  = ramaddr ^ 32'hA5A5_0000;
      end else begin
        ramstate = (use_err != 0) ? ERROR : BUSY;
        wait_cnt = wait_cnt - 1;
      end
    end else begin
      ramstate = FREE;
      wait_cnt = lat;
    end
  end

  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_completion: iwait=%0b dwait=%0b expected no completion", iwait, dwait);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("channel_is_d", {31'd0, !dwait}, {31'd0, e.is_d});
        chk("ram_addr", ramaddr, e.addr);
        if (e.is_d && e.wr)  chk("d_store", ramstore, e.data);
        else if (e.is_d)     chk("d_load", dload, e.data);
        else                 chk("i_load", iload, e.data);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(output logic is_d, output int n, output int at);
    is_d = 1'b0; n = 0; at = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) n++;
      if (!iwait || !dwait) begin
        is_d = !dwait;
        at   = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL completion_timeout: no completion within 60 cycles");
  endtask

  task automatic wait_strobe();
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) return;
    end
    checks++;
    fails++;
    $display("FAIL strobe_timeout: no RAM strobe within 60 cycles");
  endtask

  initial begin
    logic is_d;
    int   n, c0, c1, dn, inn, d_at_i;

    @(negedge CLK);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    step();
    nRST = 1'b1;

    // Single icache read, two BUSY cycles before ACCESS.
    lat = 2;
    step();
    iREN = 1'b1; iaddr = 32'h0000_0040;
    sb.push_back('{1'b0, 1'b0, 32'h0000_0040, 32'hA5A5_0040});
    wait_done(is_d, n, c0);
    chk("t1_is_i", {31'd0, is_d}, 32'd0);
    chk("t1_ramREN_cycles", n, 32'd3);
    step();
    iREN = 1'b0;

    // Two-word writeback with an icache read pending.
    lat = 0;
    step();
    iREN = 1'b1; iaddr = 32'h0000_0080;
    dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'h1111_0000;
    sb.push_back('{1'b1, 1'b1, 32'h0000_0100, 32'h1111_0000});
    sb.push_back('{1'b1, 1'b1, 32'h0000_0104, 32'h2222_0000});
    sb.push_back('{1'b0, 1'b0, 32'h0000_0080, 32'hA5A5_0080});
    wait_done(is_d, n, c0);
    step();
    daddr = 32'h0000_0104; dstore = 32'h2222_0000;
    wait_done(is_d, n, c1);
    chk("t2_no_bubble", c1 - c0, 32'd1);
    step();
    dWEN = 1'b0;
    wait_done(is_d, n, c0);
    chk("t2_i_next", {31'd0, is_d}, 32'd0);
    step();
    iREN = 1'b0;

    // Continuous dREN with iREN held: I forced in after the 4th D word.
    step();
    iREN = 1'b1; iaddr = 32'h0000_00C0;
    dREN = 1'b1; daddr = 32'h0000_0300;
    sb.push_back('{1'b1, 1'b0, 32'h0000_0300, 32'hA5A5_0300});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0304, 32'hA5A5_0304});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0308, 32'hA5A5_0308});
    sb.push_back('{1'b1, 1'b0, 32'h0000_030C, 32'hA5A5_030C});
    sb.push_back('{1'b0, 1'b0, 32'h0000_00C0, 32'hA5A5_00C0});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0310, 32'hA5A5_0310});
    sb.push_back('{1'b1, 1'b0, 32'h0000_0314, 32'hA5A5_0314});
    sb.push_back('{1'b0, 1'b0, 32'h0000_00C0, 32'hA5A5_00C0});
    dn = 0; inn = 0; d_at_i = -1;
    for (int k = 0; k < 12 && (dn < 6 || inn < 2); k++) begin
      wait_done(is_d, n, c0);
      step();
      if (is_d) begin
        dn++;
        if (dn < 6) daddr = 32'h0000_0300 + 32'(4 * dn);
        else        dREN = 1'b0;
      end else begin
        inn++;
        if (inn == 1) d_at_i = dn;
        if (inn == 2) iREN = 1'b0;
      end
    end
    chk("t3_i_after_4_d", d_at_i, 32'd4);
    dREN = 1'b0; iREN = 1'b0;

    // ERROR cycles are stalls; a single completion follows.
    lat = 3; use_err = 1;
    step();
    dREN = 1'b1; daddr = 32'h0000_0200;
    sb.push_back('{1'b1, 1'b0, 32'h0000_0200, 32'hA5A5_0200});
    wait_done(is_d, n, c0);
    chk("t4_strobe_cycles", n, 32'd4);
    step();
    dREN = 1'b0; use_err = 0;

    // Abort: dREN dropped while granted.
    lat = 5;
    step();
    dREN = 1'b1; daddr = 32'h0000_0280;
    wait_strobe();
    step();
    dREN = 1'b0;
    @(negedge CLK);
    chk("t5_ramREN_drop", {31'd0, ramREN}, 32'd0);
    chk("t5_dwait", {31'd0, dwait}, 32'd1);
    @(negedge CLK);
    chk("t5_idle", {30'd0, dut.state}, {30'd0, IDLE});

`ifdef MEMCTL_STATS_EN
    chk("stat_dr", stat_dr, 32'd7);
    chk("stat_dw", stat_dw, 32'd2);
    chk("stat_ir", stat_ir, 32'd4);
    chk("stat_err", stat_err, 32'd3);
    chk("stat_starve", stat_starve, 32'd1);
`endif

    // Reset in the middle of a granted write.
    step();
    dWEN = 1'b1; daddr = 32'h0000_0180; dstore = 32'hDEAD_BEEF;
    wait_strobe();
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("t6_dwait", {31'd0, dwait}, 32'd1);
    chk("t6_ramaddr", ramaddr, 32'd0);
    step();
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("t6_idle", {30'd0, dut.state}, {30'd0, IDLE});
    chk("t6_dwait_after", {31'd0, dwait}, 32'd1);
`ifdef MEMCTL_STATS_EN
    chk("t6_stat_cleared", stat_dr, 32'd0);
`endif

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", fails, checks);
    $finish;
  end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the pipeline's instruction and data caches. It accepts word requests from the icache and the dcache (ALLOC fills, WB0/WB1 writebacks, flush/dump writes), arbitrates them onto the single-ported RAM, and returns wait/load handshakes to each cache. It sits between the cache hierarchy and the RAM model, inside the memory subsystem.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants allowed while an icache request is pending before the icache is forced in (range 1–15).
- CLK  in  1  system clock. Single clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low for exactly the cycle iload is valid.
- iload  out  32  instruction word.
- dREN, dWEN  in  1 each  dcache read/write request (mutually exclusive; dWEN wins if both high).
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low for exactly the completing cycle.
- dload  out  32  data word.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

## Operation
- FSM memctl_state_t: IDLE, DGRANT, IGRANT.
- IDLE: if a dcache request (dREN|dWEN) is pending and the starvation counter is below STARVE_LIMIT → DGRANT. Else if iREN → IGRANT. Else stay.
- DGRANT/IGRANT drive ram strobes, address, and store data from the granted requester combinationally.
- Completion: ramstate==ACCESS while granted.
  - Lower the matching wait for that cycle only.
  - Pass ramload to iload/dload in that cycle.
  - Return to IDLE at the next edge.
- Block lock: a D completion with daddr[2]==0 while the request remains asserted goes straight back to DGRANT, not IDLE, so the two words of a block stay back-to-back.
- Starvation counter, 4 bits:
  - Increments on each D completion while iREN is high.
  - Clears on any I completion, or when iREN is low.
  - When it reaches STARVE_LIMIT, the next IDLE arbitration grants I, and the block lock is overridden.
- Requester drops its request while granted: abort. Strobes are zero in the same cycle, and the FSM returns to IDLE at the next edge with no completion.
- ramstate ERROR: treated as BUSY. Wait stays high, the request is re-presented, and the error is counted when stats are enabled.
- Address width: daddr/iaddr pass through unchanged. Low two bits are ignored by RAM.

## Timing
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0; FSM=IDLE; counters=0.
- Reset is honoured mid-transaction: strobes drop asynchronously, and no partial completion is signalled.
- Grant latency: one cycle from request in IDLE to strobes asserted.
- Minimum word latency: 2 cycles (IDLE→GRANT, then ACCESS in the same cycle the RAM answers).
- Back-to-back D block words: no IDLE bubble between word 0 and word 1.
- Simultaneous iREN and D request in IDLE: D wins unless the starvation limit has been reached.
- Waits are combinational from ramstate. Outputs are never low for more than one cycle per request.

## Configuration
- MEMCTL_STATS_EN defined:
  - Instantiates 32-bit saturating counters: d_reads, d_writes, i_reads, ram_errors, starve_forces.
  - Counters are readable on output ports stat_dr, stat_dw, stat_ir, stat_err, stat_starve. All reset to 0.
- MEMCTL_STATS_EN undefined:
  - Ports and counters are absent.
  - Arbitration behaviour is identical.

## Structure
- dp_types_pkg: memctl_state_t enum {IDLE, DGRANT, IGRANT}; localparam STARVE_W = 4.
- ramstate_t stays in cpu_types_pkg.
- Sub-module memctl_stats holds the counter bank, instantiated only under MEMCTL_STATS_EN.

## Test plan
- Single icache read at 0x0000_0040, RAM returns ACCESS after 2 BUSY cycles → iwait low for 1 cycle; iload=ramload; ramREN high for 3 cycles.
- dcache 2-word writeback at 0x100/0x104 (dWEN held) with iREN pending → two consecutive D completions with no IDLE between them; I served next.
- dREN continuously requesting 6 words with iREN held, STARVE_LIMIT=4 → I granted after 4th D completion; starve_forces=1.
- ramstate=ERROR for 3 cycles then ACCESS on a dREN at 0x200 → dwait high throughout the ERROR cycles; one completion; ram_errors=3.
- dREN dropped while in DGRANT before ACCESS → ramREN=0 that cycle; FSM IDLE next cycle; dwait never low.
- nRST asserted during DGRANT with ramWEN high → ramWEN=0 and dwait=1 immediately; FSM IDLE after release.
